// File: rtl/vx_fpu_ncp_seq.sv
// Multi-lane FP32 non-computational unit (sign-inject, min/max, compare, classify, move).
// Lanes are processed NUM_PES at a time; batches with no active lane can be skipped.
module vx_fpu_ncp_seq #(
    parameter int NUM_LANES     = 4,
    parameter int NUM_PES       = 2,
    parameter int LATENCY       = 1,
    parameter int TAG_WIDTH     = 4,
    parameter int SKIP_INACTIVE = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid_in,
    output logic                      ready_in,
    input  logic [NUM_LANES-1:0]      mask_in,
    input  logic [TAG_WIDTH-1:0]      tag_in,
    input  logic [2:0]                op_type,
    input  logic [2:0]                frm,
    input  logic [NUM_LANES*32-1:0]   dataa,
    input  logic [NUM_LANES*32-1:0]   datab,
    output logic [NUM_LANES*32-1:0]   result,
    output logic                      has_fflags,
    output logic [4:0]                fflags,
    output logic [TAG_WIDTH-1:0]      tag_out,
    output logic                      valid_out,
    input  logic                      ready_out
);

    localparam int NB = NUM_LANES / NUM_PES;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [9:0] fp_class(input logic [31:0] a);
        logic exp_ff, exp_z, man_z, s;
        logic [9:0] c;
        s      = a[31];
        exp_ff = (a[30:23] == 8'hFF);
        exp_z  = (a[30:23] == 8'h00);
        man_z  = (a[22:0] == 23'd0);
        c[0]   = s  & exp_ff & man_z;
        c[1]   = s  & !exp_ff & !exp_z;
        c[2]   = s  & exp_z & !man_z;
        c[3]   = s  & exp_z & man_z;
        c[4]   = !s & exp_z & man_z;
        c[5]   = !s & exp_z & !man_z;
        c[6]   = !s & !exp_ff & !exp_z;
        c[7]   = !s & exp_ff & man_z;
        c[8]   = exp_ff & !man_z & !a[22];
        c[9]   = exp_ff & !man_z & a[22];
        return c;
    endfunction

    // Returns {NV, result} for one lane.
    function automatic logic [32:0] fp_ncp(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op, input logic [2:0] sub);
        logic a_nan, b_nan, a_snan, b_snan, a_zero, b_zero, a_lt_b, eq, any_nan;
        logic [31:0] res;
        logic nv;
        a_nan   = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan   = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_snan  = a_nan && !a[22];
        b_snan  = b_nan && !b[22];
        any_nan = a_nan || b_nan;
        a_zero  = (a[30:0] == 31'd0);
        b_zero  = (b[30:0] == 31'd0);
        // Sign-magnitude total order: -0 sorts below +0 here, which MIN/MAX want.
        if (a[31] != b[31]) begin
            a_lt_b = a[31];
        end else if (a[31]) begin
            a_lt_b = (a[30:0] > b[30:0]);
        end else begin
            a_lt_b = (a[30:0] < b[30:0]);
        end
        eq  = (a == b) || (a_zero && b_zero);
        res = 32'd0;
        nv  = 1'b0;
        case (op)
            3'd0: res = {b[31], a[30:0]};
            3'd1: res = {~b[31], a[30:0]};
            3'd2: res = {a[31] ^ b[31], a[30:0]};
            3'd3, 3'd4: begin
                nv = a_snan || b_snan;
                if (a_nan && b_nan) begin
                    res = 32'h7FC0_0000;
                end else if (a_nan) begin
                    res = b;
                end else if (b_nan) begin
                    res = a;
                end else if ((op == 3'd3) == a_lt_b) begin
                    res = a;
                end else begin
                    res = b;
                end
            end
            3'd5: res = {22'd0, fp_class(a)};
            3'd6: begin
                case (sub)
                    3'd0: begin
                        nv  = any_nan;
                        res = {31'd0, !any_nan && ((a_lt_b && !(a_zero && b_zero)) || eq)};
                    end
                    3'd1: begin
                        nv  = any_nan;
                        res = {31'd0, !any_nan && a_lt_b && !(a_zero && b_zero)};
                    end
                    3'd2: begin
                        nv  = a_snan || b_snan;
                        res = {31'd0, !any_nan && eq};
                    end
                    default: begin
                        nv  = 1'b0;
                        res = 32'd0;
                    end
                endcase
            end
            3'd7: res = a;
            default: res = 32'd0;
        endcase
        return {nv, res};
    endfunction

    state_t                   r_state, w_state_nxt;
    logic [NUM_LANES-1:0]     r_mask;
    logic [2:0]               r_op, r_frm;
    logic [NUM_LANES*32-1:0]  r_a, r_b, r_result;
    logic [NB-1:0]            r_pending, w_act_in, w_idx_oh;
    logic [IW-1:0]            w_idx;
    logic                     w_issue, w_last, w_accept;
    logic                     r_nv, r_has_ff, r_valid, r_ready;
    logic [TAG_WIDTH-1:0]     r_tag_out;
    logic [NUM_PES*32-1:0]    w_pe_res;
    logic [NUM_PES-1:0]       w_pe_nv;
    logic [32:0]              w_lane;

    logic                     r_pv    [LATENCY];
    logic                     r_plast [LATENCY];
    logic [IW-1:0]            r_pidx  [LATENCY];
    logic [NUM_PES*32-1:0]    r_pres  [LATENCY];
    logic [NUM_PES-1:0]       r_pnv   [LATENCY];

    assign w_accept = (r_state == S_IDLE) && valid_in;
    assign w_issue  = (r_state == S_ISSUE);
    assign w_idx_oh = r_pending & (~r_pending + NB'(1'b1));
    assign w_last   = ((r_pending & ~w_idx_oh) == '0);

    // Batch activity of the incoming request and index of the next pending batch.
    always_comb begin
        w_act_in = '0;
        w_idx    = '0;
        for (int k = 0; k < NB; k++) begin
            if (SKIP_INACTIVE != 0) begin
                w_act_in[k] = |mask_in[k*NUM_PES +: NUM_PES];
            end else begin
                w_act_in[k] = 1'b1;
            end
            w_idx = w_idx | (w_idx_oh[k] ? IW'(k) : '0);
        end
    end

    // PE array: per-lane op on the selected batch, inactive lanes forced to zero.
    always_comb begin
        w_pe_res = '0;
        w_pe_nv  = '0;
        w_lane   = '0;
        for (int p = 0; p < NUM_PES; p++) begin
            w_lane = fp_ncp(r_a[(int'(w_idx)*NUM_PES + p)*32 +: 32],
                            r_b[(int'(w_idx)*NUM_PES + p)*32 +: 32], r_op, r_frm);
            if (r_mask[int'(w_idx)*NUM_PES + p]) begin
                w_pe_res[p*32 +: 32] = w_lane[31:0];
                w_pe_nv[p]           = w_lane[32];
            end else begin
                w_pe_res[p*32 +: 32] = 32'd0;
                w_pe_nv[p]           = 1'b0;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (valid_in) begin
                    w_state_nxt = (|w_act_in) ? S_ISSUE : S_DONE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: w_state_nxt = w_last ? S_WAIT : S_ISSUE;
            S_WAIT:  w_state_nxt = (r_pv[LATENCY-1] && r_plast[LATENCY-1]) ? S_DONE : S_WAIT;
            S_DONE:  w_state_nxt = ready_out ? S_IDLE : S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // PE pipeline control; flushed by reset so stale batches never land.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_pv[i]    <= 1'b0;
                r_plast[i] <= 1'b0;
            end
        end else begin
            r_pv[0]    <= w_issue;
            r_plast[0] <= w_issue && w_last;
            for (int i = 1; i < LATENCY; i++) begin
                r_pv[i]    <= r_pv[i-1];
                r_plast[i] <= r_plast[i-1];
            end
        end
    end

    // PE pipeline data.
    always_ff @(posedge clk) begin
        r_pidx[0] <= w_idx;
        r_pres[0] <= w_pe_res;
        r_pnv[0]  <= w_pe_nv;
        for (int i = 1; i < LATENCY; i++) begin
            r_pidx[i] <= r_pidx[i-1];
            r_pres[i] <= r_pres[i-1];
            r_pnv[i]  <= r_pnv[i-1];
        end
    end

    // Request capture, batch bookkeeping, FSM and output collection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_valid   <= 1'b0;
            r_mask    <= '0;
            r_op      <= 3'd0;
            r_frm     <= 3'd0;
            r_a       <= '0;
            r_b       <= '0;
            r_pending <= '0;
            r_result  <= '0;
            r_nv      <= 1'b0;
            r_has_ff  <= 1'b0;
            r_tag_out <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == S_IDLE);
            r_valid <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_mask    <= mask_in;
                r_op      <= op_type;
                r_frm     <= frm;
                r_a       <= dataa;
                r_b       <= datab;
                r_pending <= w_act_in;
                r_result  <= '0;
                r_nv      <= 1'b0;
                r_tag_out <= tag_in;
                r_has_ff  <= (op_type == 3'd3) || (op_type == 3'd4) || (op_type == 3'd6);
            end else begin
                if (w_issue) begin
                    r_pending <= r_pending & ~w_idx_oh;
                end
                if (r_pv[LATENCY-1]) begin
                    r_result[int'(r_pidx[LATENCY-1])*NUM_PES*32 +: NUM_PES*32] <= r_pres[LATENCY-1];
                    r_nv <= r_nv | (|r_pnv[LATENCY-1]);
                end
            end
        end
    end

    assign ready_in   = r_ready;
    assign valid_out  = r_valid;
    assign result     = r_result;
    assign fflags     = {r_nv, 4'b0000};
    assign tag_out    = r_tag_out;
    assign has_fflags = r_has_ff;

endmodule

// File: tb/tb_vx_fpu_ncp_seq.sv
// Bench for vx_fpu_ncp_seq: vector table with a response scoreboard plus
// hand-written backpressure, reset-abort and no-skip sequences.
module tb_vx_fpu_ncp_seq;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         valid_in = 1'b0, valid_in1 = 1'b0;
    logic         ready_out = 1'b1, ready_out1 = 1'b1;
    logic [3:0]   mask_in = 4'd0, tag_in = 4'd0;
    logic [2:0]   op_type = 3'd0, frm = 3'd0;
    logic [127:0] dataa = 128'd0, datab = 128'd0;
    logic         ready_in, valid_out, has_fflags;
    logic [127:0] result;
    logic [4:0]   fflags;
    logic [3:0]   tag_out;
    logic         ready_in1, valid_out1, has_fflags1;
    logic [127:0] result1;
    logic [4:0]   fflags1;
    logic [3:0]   tag_out1;

    always #5 clk = ~clk;

    vx_fpu_ncp_seq dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .mask_in(mask_in), .tag_in(tag_in), .op_type(op_type), .frm(frm),
        .dataa(dataa), .datab(datab), .result(result), .has_fflags(has_fflags),
        .fflags(fflags), .tag_out(tag_out), .valid_out(valid_out), .ready_out(ready_out)
    );

    vx_fpu_ncp_seq #(.SKIP_INACTIVE(0)) dut_noskip (
        .clk(clk), .reset(reset), .valid_in(valid_in1), .ready_in(ready_in1),
        .mask_in(mask_in), .tag_in(tag_in), .op_type(op_type), .frm(frm),
        .dataa(dataa), .datab(datab), .result(result1), .has_fflags(has_fflags1),
        .fflags(fflags1), .tag_out(tag_out1), .valid_out(valid_out1), .ready_out(ready_out1)
    );

    typedef struct {
        logic [3:0]   mask;
        logic [3:0]   tag;
        logic [2:0]   op;
        logic [2:0]   frm;
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] res;
        logic [4:0]   ff;
        logic         has;
        int           lat;
    } vec_t;

    typedef struct {
        logic [127:0] res;
        logic [4:0]   ff;
        logic         has;
        logic [3:0]   tag;
        int           lat;
    } exp_t;

    vec_t vt [15];
    exp_t sbq [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] m, input logic [3:0] t, input logic [2:0] o,
                                input logic [2:0] f, input logic [127:0] a, input logic [127:0] b,
                                input logic [127:0] r, input logic [4:0] ff, input logic h,
                                input int lat);
        vec_t v;
        v.mask = m; v.tag = t; v.op = o; v.frm = f; v.a = a; v.b = b;
        v.res = r; v.ff = ff; v.has = h; v.lat = lat;
        return v;
    endfunction

    task automatic drive(input logic [3:0] m, input logic [3:0] t, input logic [2:0] o,
                         input logic [2:0] f, input logic [127:0] a, input logic [127:0] b);
        mask_in = m; tag_in = t; op_type = o; frm = f; dataa = a; datab = b;
    endtask

    // Waits (bounded) for valid_out; cyc counts cycles after the acceptance edge.
    task automatic wait_valid(input string nm, output int cyc);
        cyc = 1;
        while (valid_out !== 1'b1 && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (valid_out !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.timeout: valid_out never rose within %0d cycles", nm, cyc);
        end
    endtask

    task automatic run_vec(input int i);
        string nm;
        int    cyc;
        exp_t  e;
        nm = $sformatf("v%0d", i);
        chk({nm, ".rdy_idle"}, ready_in, 1);
        drive(vt[i].mask, vt[i].tag, vt[i].op, vt[i].frm, vt[i].a, vt[i].b);
        valid_in = 1'b1;
        sbq.push_back('{res: vt[i].res, ff: vt[i].ff, has: vt[i].has, tag: vt[i].tag, lat: vt[i].lat});
        @(posedge clk); #1;
        valid_in = 1'b0;
        chk({nm, ".rdy_busy"}, ready_in, 0);
        wait_valid(nm, cyc);
        e = sbq.pop_front();
        if (valid_out === 1'b1) begin
            chk({nm, ".result"}, result, e.res);
            chk({nm, ".fflags"}, fflags, e.ff);
            chk({nm, ".has_fflags"}, has_fflags, e.has);
            chk({nm, ".tag"}, tag_out, e.tag);
            chk({nm, ".latency"}, cyc, e.lat);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int   cyc;
        exp_t e;
        logic seen;

        vt[0]  = mk(4'b1111, 4'h5, 3'd7, 3'd0, {32'd4, 32'd3, 32'd2, 32'd1}, 128'd0,
                    {32'd4, 32'd3, 32'd2, 32'd1}, 5'b00000, 1'b0, 4);
        vt[1]  = mk(4'b0011, 4'h6, 3'd7, 3'd0, {32'd4, 32'd3, 32'd2, 32'd1}, 128'd0,
                    {32'd0, 32'd0, 32'd2, 32'd1}, 5'b00000, 1'b0, 3);
        vt[2]  = mk(4'b0000, 4'h9, 3'd7, 3'd0, {32'd4, 32'd3, 32'd2, 32'd1}, 128'd0,
                    128'd0, 5'b00000, 1'b0, 1);
        vt[3]  = mk(4'b1111, 4'hA, 3'd3, 3'd0,
                    {32'h7FC00000, 32'h80000000, 32'hBF800000, 32'h7F800001},
                    {32'h7FC00001, 32'h00000000, 32'h40000000, 32'h3F800000},
                    {32'h7FC00000, 32'h80000000, 32'hBF800000, 32'h3F800000}, 5'b10000, 1'b1, 4);
        vt[4]  = mk(4'b1110, 4'hB, 3'd3, 3'd0,
                    {32'h7FC00000, 32'h80000000, 32'hBF800000, 32'h7F800001},
                    {32'h7FC00001, 32'h00000000, 32'h40000000, 32'h3F800000},
                    {32'h7FC00000, 32'h80000000, 32'hBF800000, 32'h00000000}, 5'b00000, 1'b1, 4);
        vt[5]  = mk(4'b1111, 4'hC, 3'd4, 3'd0,
                    {32'h7F800000, 32'hC0000000, 32'h80000000, 32'h3F800000},
                    {32'hFF800000, 32'hBF800000, 32'h00000000, 32'h7FC00000},
                    {32'h7F800000, 32'hBF800000, 32'h00000000, 32'h3F800000}, 5'b00000, 1'b1, 4);
        vt[6]  = mk(4'b1111, 4'hD, 3'd6, 3'd1,
                    {32'h40000000, 32'h80000000, 32'h3F800000, 32'h7FC00000},
                    {32'h3F800000, 32'h00000000, 32'h40000000, 32'h00000000},
                    {32'd0, 32'd0, 32'd1, 32'd0}, 5'b10000, 1'b1, 4);
        vt[7]  = mk(4'b1111, 4'hE, 3'd6, 3'd2,
                    {32'h3F800000, 32'h3F800000, 32'h80000000, 32'h7FC00000},
                    {32'h40000000, 32'h3F800000, 32'h00000000, 32'h00000000},
                    {32'd0, 32'd1, 32'd1, 32'd0}, 5'b00000, 1'b1, 4);
        vt[8]  = mk(4'b1111, 4'hF, 3'd6, 3'd0,
                    {32'h40400000, 32'h7F800001, 32'hBF800000, 32'h40000000},
                    {32'h40000000, 32'h00000000, 32'h3F800000, 32'h40000000},
                    {32'd0, 32'd0, 32'd1, 32'd1}, 5'b10000, 1'b1, 4);
        vt[9]  = mk(4'b1111, 4'h1, 3'd5, 3'd0,
                    {32'h80000000, 32'h7F800001, 32'h00000001, 32'hFF800000}, 128'd0,
                    {32'h008, 32'h100, 32'h020, 32'h001}, 5'b00000, 1'b0, 4);
        vt[10] = mk(4'b1111, 4'h2, 3'd0, 3'd0,
                    {32'hC0000000, 32'h40000000, 32'hBF800000, 32'h3F800000},
                    {32'hC0000000, 32'hC0000000, 32'h00000000, 32'h80000000},
                    {32'hC0000000, 32'hC0000000, 32'h3F800000, 32'hBF800000}, 5'b00000, 1'b0, 4);
        vt[11] = mk(4'b1111, 4'h3, 3'd1, 3'd0,
                    {32'hC0000000, 32'h40000000, 32'hBF800000, 32'h3F800000},
                    {32'hC0000000, 32'hC0000000, 32'h00000000, 32'h80000000},
                    {32'h40000000, 32'h40000000, 32'hBF800000, 32'h3F800000}, 5'b00000, 1'b0, 4);
        vt[12] = mk(4'b1111, 4'h4, 3'd2, 3'd0,
                    {32'hC0000000, 32'h40000000, 32'hBF800000, 32'h3F800000},
                    {32'hC0000000, 32'hC0000000, 32'h00000000, 32'h80000000},
                    {32'h40000000, 32'hC0000000, 32'hBF800000, 32'hBF800000}, 5'b00000, 1'b0, 4);
        vt[13] = mk(4'b1100, 4'h7, 3'd7, 3'd0, {32'd4, 32'd3, 32'd2, 32'd1}, 128'd0,
                    {32'd4, 32'd3, 32'd0, 32'd0}, 5'b00000, 1'b0, 3);
        vt[14] = mk(4'b0101, 4'h8, 3'd7, 3'd0, {32'd4, 32'd3, 32'd2, 32'd1}, 128'd0,
                    {32'd0, 32'd3, 32'd0, 32'd1}, 5'b00000, 1'b0, 4);

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready_in", ready_in, 1);
        chk("rst.valid_out", valid_out, 0);
        chk("rst.result", result, 0);
        chk("rst.fflags", fflags, 0);
        chk("rst.tag_out", tag_out, 0);
        chk("rst.has_fflags", has_fflags, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            run_vec(i);
        end

        // All batches issued even when half the mask is zero.
        drive(4'b0011, 4'h3, 3'd7, 3'd0, {32'd4, 32'd3, 32'd2, 32'd1}, 128'd0);
        chk("noskip.rdy_idle", ready_in1, 1);
        valid_in1 = 1'b1;
        @(posedge clk); #1;
        valid_in1 = 1'b0;
        cyc = 1;
        while (valid_out1 !== 1'b1 && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("noskip.latency", cyc, 4);
        chk("noskip.result", result1, {32'd0, 32'd0, 32'd2, 32'd1});
        chk("noskip.tag", tag_out1, 4'h3);
        chk("noskip.flags", {has_fflags1, fflags1}, 6'd0);
        @(posedge clk); #1;

        // Backpressure: response held for 5 cycles while a new request is offered.
        ready_out = 1'b0;
        drive(4'b1111, 4'h6, 3'd4, 3'd0,
              {32'h7F800001, 32'h40000000, 32'h3F800000, 32'h00000000},
              {32'h3F800000, 32'h3F800000, 32'h40000000, 32'h80000000});
        valid_in = 1'b1;
        sbq.push_back('{res: {32'h3F800000, 32'h40000000, 32'h40000000, 32'h00000000},
                        ff: 5'b10000, has: 1'b1, tag: 4'h6, lat: 4});
        @(posedge clk); #1;
        drive(4'b1111, 4'h3, 3'd7, 3'd0, {4{32'hDEADBEEF}}, 128'd0);
        wait_valid("bp", cyc);
        e = sbq.pop_front();
        chk("bp.latency", cyc, e.lat);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp.valid%0d", k), valid_out, 1);
            chk($sformatf("bp.ready_in%0d", k), ready_in, 0);
            chk($sformatf("bp.result%0d", k), result, e.res);
            chk($sformatf("bp.tag%0d", k), tag_out, e.tag);
            chk($sformatf("bp.fflags%0d", k), fflags, e.ff);
        end
        valid_in = 1'b0;
        ready_out = 1'b1;
        @(posedge clk); #1;
        chk("bp.release_valid", valid_out, 0);
        chk("bp.release_ready", ready_in, 1);

        // Reset while batches are being issued discards the request.
        drive(4'b1111, 4'h2, 3'd7, 3'd0, {32'd8, 32'd7, 32'd6, 32'd5}, 128'd0);
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        chk("rstmid.busy", ready_in, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rstmid.valid_out", valid_out, 0);
        chk("rstmid.ready_in", ready_in, 1);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            seen = seen | valid_out;
        end
        chk("rstmid.no_stale_resp", seen, 0);
        run_vec(3);
        run_vec(0);

        chk("sb.empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_fpu_ncp_seq.md
Name: vx_fpu_ncp_seq

Overview:
- Multi-lane FP32 non-computational unit: sign-inject, min/max, compare, classify, move.
- Sits in the FPU beside the DSP arithmetic units. NUM_LANES lanes share NUM_PES processing elements through a built-in batch sequencer.
- Successor to the fixed-ratio NCP unit. Adds a configurable PE pipeline depth and mask-driven skipping of all-inactive batches, so sparse warps finish sooner.
- Per-op fflags are merged over active lanes only.

Parameters:
- NUM_LANES, 4: lanes per request. Must be a multiple of NUM_PES.
- NUM_PES, 2: physical PEs. Number of batches B = NUM_LANES/NUM_PES.
- LATENCY, 1: PE pipeline depth in cycles, ≥1.
- TAG_WIDTH, 4: width of the opaque tag carried with the request.
- SKIP_INACTIVE, 1: 1 = batches with all-zero mask are not issued.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- valid_in  in  1  request valid
- ready_in  out  1  unit can accept a request
- mask_in  in  NUM_LANES  active-lane mask
- tag_in  in  TAG_WIDTH  request tag
- op_type  in  3  0 SGNJ, 1 SGNJN, 2 SGNJX, 3 MIN, 4 MAX, 5 CLASS, 6 CMP, 7 MV
- frm  in  3  CMP sub-op: 0 LE, 1 LT, 2 EQ; ignored for other ops
- dataa  in  NUM_LANES*32  operand A per lane
- datab  in  NUM_LANES*32  operand B per lane
- result  out  NUM_LANES*32  per-lane result; inactive lanes = 0
- has_fflags  out  1  1 for MIN, MAX, CMP; else 0
- fflags  out  5  {NV,DZ,OF,UF,NX}, OR over active lanes
- tag_out  out  TAG_WIDTH  tag of the returned request
- valid_out  out  1  response valid
- ready_out  in  1  downstream accepts response

Behaviour:
- Clock and reset: single clock clk; reset synchronous, active-high.
- FSM states:
  - IDLE: ready_in=1. On valid_in&&ready_in, latch mask, tag, op, frm and operands. Go to ISSUE, or to DONE if no batch is issued.
  - ISSUE: one active batch per cycle into the PE pipe (pe_enable=1). After the last active batch is issued, go to WAIT.
  - WAIT: hold until the last batch leaves the pipe, then go to DONE.
  - DONE: valid_out=1. On ready_out, go to IDLE. ready_in=0 in every state except IDLE, so only one request is in flight.
- Batch selection: batch k covers lanes [k*NUM_PES, (k+1)*NUM_PES).
  - With SKIP_INACTIVE=1, batches whose mask slice is zero are skipped; the next active batch is found combinationally in the same cycle.
  - With SKIP_INACTIVE=0, all B batches are issued.
- Timing: let A = number of issued batches. The acceptance edge is cycle 0.
  - Issued batches occupy cycles 1..A.
  - Each batch's results are written into the output collection register LATENCY cycles after issue.
  - valid_out first goes high in cycle A+LATENCY+1.
  - A=0 (mask all zero, SKIP_INACTIVE=1): valid_out high in cycle 1, results 0, fflags 0.
- Backpressure: the PE pipe is never stalled. The collection register holds result, fflags and tag stable while valid_out=1 and ready_out=0.
- Ops, per lane, IEEE-754 binary32:
  - SGNJ/SGNJN/SGNJX: {sign(b), ~sign(b), sign(a)^sign(b)} concatenated with a[30:0].
  - MIN/MAX:
    - -0 < +0.
    - One NaN operand: return the other operand.
    - Both NaN: return canonical 0x7FC00000.
    - NV set if either operand is sNaN.
  - CMP: result 0 or 1.
    - LE/LT: NV set if either operand is any NaN.
    - EQ: NV set only on sNaN.
    - Any NaN operand: result 0.
  - CLASS: 10-bit one-hot in result[9:0], bits 0..9 = -inf, -norm, -sub, -0, +0, +sub, +norm, +inf, sNaN, qNaN. Upper bits 0.
  - MV: result = dataa.
- fflags: OR of per-lane flags over active lanes only. DZ, OF, UF and NX are always 0.
- Reset values: ready_in=1, valid_out=0, result=0, fflags=0, tag_out=0, has_fflags=0; FSM=IDLE. Reset in any state discards in-flight batches and the pending response.
- valid_in while not IDLE: ignored, with ready_in=0.

Test Plan:
- NUM_LANES=4, NUM_PES=2, LATENCY=1, mask=1111, MV, dataa={1,2,3,4}:
  - ready_in low from cycle 1.
  - valid_out in cycle 4 with result={1,2,3,4}.
  - has_fflags=0.
- mask=0011, SKIP_INACTIVE=1:
  - only batch 0 issued; valid_out in cycle 3.
  - lanes 2–3 result 0.
  - repeat with SKIP_INACTIVE=0: valid_out in cycle 4.
- mask=0000, SKIP_INACTIVE=1 → valid_out in cycle 1, result all 0, fflags 0, tag_out=tag_in.
- MIN, lane0 a=0x7F800001 (sNaN), b=0x3F800000, other lanes active with normal values → lane0 result=0x3F800000, fflags=10000, has_fflags=1.
  - Same sNaN in an inactive lane → fflags=00000.
- CMP LT, a=0x7FC00000, b=0 → result 0, NV=1. CMP EQ with the same operands → result 0, NV=0.
- Hold ready_out=0 for 5 cycles in DONE: outputs stable, ready_in=0.
  - Assert reset for 1 cycle mid-ISSUE: next cycle valid_out=0, ready_in=1, and a new request completes normally.
